// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM encoding, BHT geometry,
// predecode opcodes, reset pc and RISC-V immediate extraction helpers.
package if_stage_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_HOLD = 2'd2,
        ST_DROP = 2'd3
    } fetch_state_t;

    localparam int          BHT_ENTRIES = 64;
    localparam int          BHT_IDX_W   = 6;
    localparam logic [1:0]  BHT_INIT    = 2'b01;

    localparam logic [6:0]  OPC_JAL     = 7'b1101111;
    localparam logic [6:0]  OPC_BRANCH  = 7'b1100011;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;

    function automatic logic [31:0] j_imm(input logic [31:0] inst);
        return {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

    function automatic logic [31:0] b_imm(input logic [31:0] inst);
        return {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
    endfunction

endpackage

// File: rtl/if_bht.sv
// Branch history table: 2-bit saturating counters with an asynchronous read port
// and a synchronous update port, so a same-cycle read sees the pre-update value.
module if_bht
    import if_stage_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [BHT_IDX_W-1:0] rd_idx,
    output logic [1:0]           rd_ctr,
    input  logic                 upd_valid,
    input  logic [BHT_IDX_W-1:0] upd_idx,
    input  logic                 upd_taken
);

    logic [1:0] ctr [BHT_ENTRIES];

    assign rd_ctr = ctr[rd_idx];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                ctr[i] <= BHT_INIT;
            end
        end else if (upd_valid) begin
            if (upd_taken && ctr[upd_idx] != 2'b11) begin
                ctr[upd_idx] <= ctr[upd_idx] + 2'd1;
            end else if (!upd_taken && ctr[upd_idx] != 2'b00) begin
                ctr[upd_idx] <= ctr[upd_idx] - 2'd1;
            end
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: single-outstanding memory fetch, predecode with static
// JAL / BHT-predicted branch redirect, one-entry hold buffer and flush handling.
module if_stage
    import if_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_ready,
    input  logic        mem_valid,
    input  logic [31:0] mem_rdata,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] flush_target,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instruction,
    output logic        if_prediction,
    output logic [1:0]  dbg_state
);

    // Handshakes: a request transfers on a cycle with mem_req && mem_ready; the
    // response is the single cycle with mem_valid in WAIT. A word on if_* is
    // consumed by ID on a cycle with if_valid && !stall.

    fetch_state_t state, state_d;
    logic [31:0]  pc, pc_d;
    logic         pc_load;
    logic         load_fetch, load_hold, capture_hold;

    logic [31:0]  hold_pc, hold_instr;
    logic         hold_pred;

    logic [1:0]   bht_ctr;
    logic [31:0]  fetch_next_pc;
    logic         fetch_pred;

    logic         unused_upd_bits;
    assign unused_upd_bits = ^{upd_pc[31:8], upd_pc[1:0]};

    if_bht u_bht (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (pc[7:2]),
        .rd_ctr    (bht_ctr),
        .upd_valid (upd_valid),
        .upd_idx   (upd_pc[7:2]),
        .upd_taken (upd_taken)
    );

    // Predecode of the returning word; JALR is deliberately not predicted.
    always_comb begin
        fetch_pred    = 1'b0;
        fetch_next_pc = pc + 32'd4;
        if (mem_rdata[6:0] == OPC_JAL) begin
            fetch_pred    = 1'b1;
            fetch_next_pc = pc + j_imm(mem_rdata);
        end else if (mem_rdata[6:0] == OPC_BRANCH && bht_ctr[1]) begin
            fetch_pred    = 1'b1;
            fetch_next_pc = pc + b_imm(mem_rdata);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
        end else begin
            state <= state_d;
            if (pc_load) begin
                pc <= pc_d;
            end
        end
    end

    // mem_req depends on state only, keeping mem_valid off the request path.
    always_comb begin
        state_d      = state;
        pc_d         = fetch_next_pc;
        pc_load      = 1'b0;
        load_fetch   = 1'b0;
        load_hold    = 1'b0;
        capture_hold = 1'b0;
        mem_req      = (state == ST_IDLE);
        if (flush) begin
            pc_d    = flush_target;
            pc_load = 1'b1;
            case (state)
                ST_IDLE: state_d = mem_ready ? ST_DROP : ST_IDLE;
                ST_WAIT: state_d = ST_DROP;
                ST_HOLD: state_d = ST_IDLE;
                default: state_d = ST_DROP;
            endcase
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mem_ready) begin
                        state_d = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (mem_valid) begin
                        pc_load = 1'b1;
                        if (!if_valid || !stall) begin
                            load_fetch = 1'b1;
                            state_d    = ST_IDLE;
                        end else begin
                            capture_hold = 1'b1;
                            state_d      = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        load_hold = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
                default: begin
                    if (mem_valid) begin
                        state_d = ST_IDLE;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            if_valid       <= 1'b0;
            if_pc          <= 32'h0;
            if_instruction <= 32'h0;
            if_prediction  <= 1'b0;
        end else if (flush) begin
            if_valid <= 1'b0;
        end else if (load_fetch) begin
            if_valid       <= 1'b1;
            if_pc          <= pc;
            if_instruction <= mem_rdata;
            if_prediction  <= fetch_pred;
        end else if (load_hold) begin
            if_valid       <= 1'b1;
            if_pc          <= hold_pc;
            if_instruction <= hold_instr;
            if_prediction  <= hold_pred;
        end else if (if_valid && !stall) begin
            if_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_pc    <= 32'h0;
            hold_instr <= 32'h0;
            hold_pred  <= 1'b0;
        end else if (flush) begin
            hold_pc    <= 32'h0;
            hold_instr <= 32'h0;
            hold_pred  <= 1'b0;
        end else if (capture_hold) begin
            hold_pc    <= pc;
            hold_instr <= mem_rdata;
            hold_pred  <= fetch_pred;
        end
    end

    assign mem_addr  = pc;
    assign dbg_state = state;

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: hand-built fetch responses, an expected queue of
// delivered {pc, instruction, prediction} words, and direct state/address checks.
module tb_if_stage;

    localparam logic [1:0]  S_IDLE = 2'd0;
    localparam logic [1:0]  S_WAIT = 2'd1;
    localparam logic [1:0]  S_HOLD = 2'd2;
    localparam logic [1:0]  S_DROP = 2'd3;

    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] JAL8  = 32'h0080_006F;
    localparam logic [31:0] JAL32 = 32'h0200_006F;
    localparam logic [31:0] BEQM4 = 32'hFE00_0EE3;
    localparam logic [31:0] JALR  = 32'h0000_80E7;
    localparam logic [31:0] ADDI1 = 32'h0010_0093;
    localparam logic [31:0] ADDI2 = 32'h0020_0113;

    logic        clk;
    logic        rst;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready;
    logic        mem_valid;
    logic [31:0] mem_rdata;
    logic        stall;
    logic        flush;
    logic [31:0] flush_target;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instruction;
    logic        if_prediction;
    logic [1:0]  dbg_state;

    logic [64:0] exp_q[$];
    int          n_cmp;
    int          n_err;

    if_stage dut (
        .clk            (clk),
        .rst            (rst),
        .mem_req        (mem_req),
        .mem_addr       (mem_addr),
        .mem_ready      (mem_ready),
        .mem_valid      (mem_valid),
        .mem_rdata      (mem_rdata),
        .stall          (stall),
        .flush          (flush),
        .flush_target   (flush_target),
        .upd_valid      (upd_valid),
        .upd_pc         (upd_pc),
        .upd_taken      (upd_taken),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instruction (if_instruction),
        .if_prediction  (if_prediction),
        .dbg_state      (dbg_state)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic void push_exp(input logic [31:0] pc, input logic [31:0] instr, input logic pred);
        exp_q.push_back({pc, instr, pred});
    endfunction

    // Scoreboard: every word ID consumes must be the next expected one.
    initial begin
        logic [64:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst && if_valid && !stall && !flush) begin
                check_val("out_avail", 65'(exp_q.size() != 0), 65'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check_val("out_word", {if_pc, if_instruction, if_prediction}, e);
                end
            end
        end
    end

    // Driver: issue one fetch at exp_addr and return word lat cycles after acceptance.
    task automatic fetch(input logic [31:0] exp_addr, input logic [31:0] word, input int lat,
                         input logic upd_en, input logic upd_tk);
        int n;
        n = 0;
        mem_ready = 1'b1;
        while (!mem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_val("req_wait", 65'(mem_req), 65'd1);
        check_val("mem_addr", 65'(mem_addr), 65'(exp_addr));
        @(negedge clk);
        mem_ready = 1'b0;
        repeat (lat - 1) @(negedge clk);
        mem_valid = 1'b1;
        mem_rdata = word;
        if (upd_en) begin
            upd_valid = 1'b1;
            upd_pc    = exp_addr;
            upd_taken = upd_tk;
        end
        @(negedge clk);
        mem_valid = 1'b0;
        mem_rdata = 32'h0;
        upd_valid = 1'b0;
    endtask

    task automatic bht_update(input logic taken);
        upd_valid = 1'b1;
        upd_pc    = 32'h20;
        upd_taken = taken;
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    task automatic do_flush(input logic [31:0] target);
        flush        = 1'b1;
        flush_target = target;
        @(negedge clk);
        flush = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b0;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        mem_rdata = 32'h0;
        stall = 1'b0;
        flush = 1'b0;
        flush_target = 32'h0;
        upd_valid = 1'b0;
        upd_pc = 32'h0;
        upd_taken = 1'b0;

        repeat (3) @(negedge clk);
        check_val("rst_valid", 65'(if_valid), 65'd0);
        check_val("rst_pc", 65'(if_pc), 65'd0);
        check_val("rst_instr", 65'(if_instruction), 65'd0);
        check_val("rst_pred", 65'(if_prediction), 65'd0);
        check_val("rst_state", 65'(dbg_state), 65'(S_IDLE));
        check_val("rst_addr", 65'(mem_addr), 65'd0);
        rst = 1'b1;

        // Sequential NOP fetches, then a JAL redirect
        push_exp(32'h0, NOP, 1'b0);  fetch(32'h0, NOP, 2, 1'b0, 1'b0);
        push_exp(32'h4, NOP, 1'b0);  fetch(32'h4, NOP, 2, 1'b0, 1'b0);
        push_exp(32'h8, NOP, 1'b0);  fetch(32'h8, NOP, 2, 1'b0, 1'b0);
        push_exp(32'hC, NOP, 1'b0);  fetch(32'hC, NOP, 1, 1'b0, 1'b0);
        push_exp(32'h10, JAL8, 1'b1); fetch(32'h10, JAL8, 1, 1'b0, 1'b0);
        push_exp(32'h18, NOP, 1'b0); fetch(32'h18, NOP, 1, 1'b0, 1'b0);

        // BHT training at index 8 (pc 0x20): 01 -> 10 -> 11
        bht_update(1'b1);
        bht_update(1'b1);
        push_exp(32'h1C, NOP, 1'b0);   fetch(32'h1C, NOP, 1, 1'b0, 1'b0);
        push_exp(32'h20, BEQM4, 1'b1); fetch(32'h20, BEQM4, 1, 1'b0, 1'b0);
        push_exp(32'h1C, NOP, 1'b0);   fetch(32'h1C, NOP, 1, 1'b0, 1'b0);
        // Saturated taken stays 11; one not-taken gives 10, still predicts taken
        bht_update(1'b1);
        bht_update(1'b0);
        push_exp(32'h20, BEQM4, 1'b1); fetch(32'h20, BEQM4, 1, 1'b0, 1'b0);
        push_exp(32'h1C, NOP, 1'b0);   fetch(32'h1C, NOP, 1, 1'b0, 1'b0);
        // 10 -> 01; a same-cycle taken update must not affect this prediction
        bht_update(1'b0);
        push_exp(32'h20, BEQM4, 1'b0); fetch(32'h20, BEQM4, 1, 1'b1, 1'b1);
        push_exp(32'h24, JALR, 1'b0);  fetch(32'h24, JALR, 1, 1'b0, 1'b0);
        @(negedge clk);

        // Hold buffer under stall
        stall = 1'b1;
        push_exp(32'h28, ADDI1, 1'b0); fetch(32'h28, ADDI1, 1, 1'b0, 1'b0);
        push_exp(32'h2C, ADDI2, 1'b0); fetch(32'h2C, ADDI2, 1, 1'b0, 1'b0);
        check_val("hold_state", 65'(dbg_state), 65'(S_HOLD));
        check_val("hold_noreq", 65'(mem_req), 65'd0);
        check_val("hold_ifpc", 65'(if_pc), 65'h28);
        repeat (2) @(negedge clk);
        check_val("hold_state2", 65'(dbg_state), 65'(S_HOLD));
        check_val("hold_noreq2", 65'(mem_req), 65'd0);
        stall = 1'b0;
        @(negedge clk);
        check_val("unhold_state", 65'(dbg_state), 65'(S_IDLE));
        check_val("unhold_ifpc", 65'(if_pc), 65'h2C);
        check_val("unhold_valid", 65'(if_valid), 65'd1);
        @(negedge clk);
        check_val("unhold_addr", 65'(mem_addr), 65'h30);

        // Flush in WAIT drops the returning word
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check_val("wait_state", 65'(dbg_state), 65'(S_WAIT));
        do_flush(32'h100);
        check_val("drop_state", 65'(dbg_state), 65'(S_DROP));
        check_val("drop_noreq", 65'(mem_req), 65'd0);
        mem_valid = 1'b1;
        mem_rdata = JAL8;
        @(negedge clk);
        mem_valid = 1'b0;
        check_val("drop_valid", 65'(if_valid), 65'd0);
        check_val("drop_exit", 65'(dbg_state), 65'(S_IDLE));
        check_val("drop_addr", 65'(mem_addr), 65'h100);
        push_exp(32'h100, NOP, 1'b0); fetch(32'h100, NOP, 1, 1'b0, 1'b0);
        @(negedge clk);

        // Flush in HOLD discards both the stalled word and the hold buffer
        stall = 1'b1;
        fetch(32'h104, ADDI1, 1, 1'b0, 1'b0);
        fetch(32'h108, ADDI2, 1, 1'b0, 1'b0);
        check_val("hold2_state", 65'(dbg_state), 65'(S_HOLD));
        do_flush(32'h200);
        check_val("hflush_state", 65'(dbg_state), 65'(S_IDLE));
        check_val("hflush_valid", 65'(if_valid), 65'd0);
        check_val("hflush_addr", 65'(mem_addr), 65'h200);
        stall = 1'b0;
        @(negedge clk);
        check_val("hflush_valid2", 65'(if_valid), 65'd0);
        push_exp(32'h200, NOP, 1'b0); fetch(32'h200, NOP, 1, 1'b0, 1'b0);
        @(negedge clk);

        // Stray response in IDLE is ignored
        mem_valid = 1'b1;
        mem_rdata = JAL8;
        @(negedge clk);
        mem_valid = 1'b0;
        check_val("stray_valid", 65'(if_valid), 65'd0);
        check_val("stray_state", 65'(dbg_state), 65'(S_IDLE));
        check_val("stray_addr", 65'(mem_addr), 65'h204);

        // Flush in IDLE without acceptance, then pc wraps to 0
        do_flush(32'hFFFF_FFFC);
        check_val("iflush_state", 65'(dbg_state), 65'(S_IDLE));
        push_exp(32'hFFFF_FFFC, NOP, 1'b0); fetch(32'hFFFF_FFFC, NOP, 1, 1'b0, 1'b0);
        push_exp(32'h0, NOP, 1'b0);         fetch(32'h0, NOP, 1, 1'b0, 1'b0);
        @(negedge clk);

        // Reset during WAIT with the response arriving inside reset
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        check_val("rwait_state", 65'(dbg_state), 65'(S_WAIT));
        rst = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1;
        mem_rdata = JAL8;
        @(negedge clk);
        mem_valid = 1'b0;
        @(negedge clk);
        check_val("rmid_valid", 65'(if_valid), 65'd0);
        check_val("rmid_state", 65'(dbg_state), 65'(S_IDLE));
        check_val("rmid_ifpc", 65'(if_pc), 65'd0);
        rst = 1'b1;
        check_val("rel_req", 65'(mem_req), 65'd1);
        check_val("rel_addr", 65'(mem_addr), 65'd0);
        push_exp(32'h0, JAL32, 1'b1);   fetch(32'h0, JAL32, 1, 1'b0, 1'b0);
        push_exp(32'h20, BEQM4, 1'b0);  fetch(32'h20, BEQM4, 1, 1'b0, 1'b0);
        push_exp(32'h24, NOP, 1'b0);    fetch(32'h24, NOP, 1, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check_val("leftover", 65'(exp_q.size()), 65'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1; reset is asynchronous and active-low.
REQ-003 SHALL have ports mem_req (out, 1), mem_addr (out, 32), mem_ready (in, 1): instruction fetch request, accepted when mem_req && mem_ready.
REQ-004 SHALL have ports mem_valid (in, 1), mem_rdata (in, 32): fetch response, at least 1 cycle after acceptance; single outstanding request.
REQ-005 SHALL have port stall, input, 1, from stall bus; ID cannot accept output this cycle.
REQ-006 SHALL have ports flush (in, 1), flush_target (in, 32): EX misprediction redirect.
REQ-007 SHALL have ports upd_valid (in, 1), upd_pc (in, 32), upd_taken (in, 1): resolved conditional-branch outcome for BHT training.
REQ-008 SHALL have ports if_valid (out, 1), if_pc (out, 32), if_instruction (out, 32), if_prediction (out, 1), all registered, feeding IF_ID.

Function
REQ-009 SHALL implement FSM states IDLE, WAIT, HOLD, DROP.
REQ-010 IDLE: mem_req=1, mem_addr=pc; on mem_ready go WAIT; mem_req=0 in every other state.
REQ-011 WAIT, mem_valid, output slot free (!if_valid or !stall): load if_* from pc, mem_rdata, prediction; pc<=next_pc; go IDLE.
REQ-012 WAIT, mem_valid, slot blocked (if_valid && stall): capture pc, rdata, prediction in hold buffer; pc<=next_pc; go HOLD.
REQ-013 HOLD: when !stall, move hold buffer into if_*; go IDLE; no request issued while in HOLD.
REQ-014 if_valid SHALL clear when if_valid && !stall and no new load occurs that cycle.
REQ-015 Predecode of fetched word: opcode 1101111 (JAL) -> next_pc=pc+J_imm, prediction=1.
REQ-016 opcode 1100011 (branch) with BHT[pc[7:2]][1]=1 -> next_pc=pc+B_imm, prediction=1; all other cases next_pc=pc+4, prediction=0 (JALR included).
REQ-017 Immediates SHALL be sign-extended RISC-V J/B formats; pc arithmetic modulo 2^32, wrap from 0xFFFFFFFC to 0 silent.
REQ-018 BHT SHALL be 64 entries x 2-bit saturating counters indexed by pc[7:2]; upd_valid increments (taken) or decrements toward 00/11 limits.
REQ-019 BHT read and update same index same cycle: prediction uses pre-update value.
REQ-020 flush has priority over all other events: if_valid<=0, hold buffer discarded, pc<=flush_target.
REQ-021 flush in WAIT, or in IDLE with accepted request same cycle -> DROP; flush in HOLD or IDLE without acceptance -> IDLE.
REQ-022 DROP: discard the next mem_valid, then go IDLE; flush in DROP updates pc only, stays DROP.
REQ-023 mem_valid outside WAIT/DROP SHALL be ignored.

Reset
REQ-024 On rst low: state=IDLE, pc=0x00000000, if_valid=0, if_pc=0, if_instruction=0, if_prediction=0, hold buffer cleared, all BHT entries=01.
REQ-025 Reset mid-transaction SHALL abandon any outstanding response; first request after release is addr 0 in the first cycle with rst high.

Structure
REQ-026 FSM state encoding, BHT size/index width, opcode constants (JAL, BRANCH) and reset pc SHALL live in the shared defines file.
REQ-027 BHT SHALL be a sub-module if_bht (read port index, update port, synchronous write, async reset).
REQ-028 Target RTL size 150-300 lines; no latches; no combinational path from mem_valid to mem_req.

Verification
REQ-029 Reset release, mem_ready=1, 2-cycle latency, rdata 0x00000013 -> mem_addr 0,4,8 successive; if_pc 0,4 with if_prediction=0.
REQ-030 Fetch 0x0080006F (JAL +8) at pc 0x10 -> if_prediction=1, next mem_addr 0x18.
REQ-031 Train upd_pc=0x20 taken twice, then fetch 0xFE000EE3 (BEQ -4) at 0x20 -> prediction=1, next mem_addr 0x1C; counter saturates at 11 after third update.
REQ-032 if_valid=1, stall=1 during response -> state HOLD, no mem_req; stall drop -> buffered word appears on if_* next cycle, no loss/duplication.
REQ-033 flush target 0x100 while in WAIT -> returning word discarded, if_valid=0, next mem_addr 0x100.
REQ-034 rst low while in WAIT, response arrives during reset -> ignored; after release mem_addr 0, all BHT predictions 0.
